// File: rtl/board_renderer.sv
// Repaints the 10x20 board from board RAM onto the VGA frame as 4x4-pixel cells.
// 18 cycles per cell (addr, latch, 16 draws); busy for 3601 cycles; the VGA port has no backpressure.
module board_renderer #(
    parameter logic [7:0] X0        = 8'd60,
    parameter logic [6:0] Y0        = 7'd20,
    parameter logic [5:0] BG_COLOUR = 6'b000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] ram_addr,
    input  logic [5:0] ram_q,
    output logic [7:0] X,
    output logic [6:0] Y,
    output logic [5:0] colour,
    output logic       writeEn,
    output logic       busy,
    output logic       complete
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LATCH,
        S_DRAW,
        S_DONE
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] col, col_nxt;
    logic [4:0] row, row_nxt;
    logic [3:0] px, px_nxt;
    logic [5:0] cell_colour, cell_colour_nxt;
    logic [7:0] cell_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            col         <= 4'd0;
            row         <= 5'd0;
            px          <= 4'd0;
            cell_colour <= 6'd0;
        end else begin
            state       <= state_nxt;
            col         <= col_nxt;
            row         <= row_nxt;
            px          <= px_nxt;
            cell_colour <= cell_colour_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        col_nxt         = col;
        row_nxt         = row;
        px_nxt          = px;
        cell_colour_nxt = cell_colour;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ADDR;
                    col_nxt   = 4'd0;
                    row_nxt   = 5'd0;
                    px_nxt    = 4'd0;
                end
            end
            S_ADDR:  state_nxt = S_LATCH;
            S_LATCH: begin
                // RAM data is only trusted here, one cycle after the address was presented
                cell_colour_nxt = (ram_q == 6'd0) ? BG_COLOUR : ram_q;
                state_nxt       = S_DRAW;
            end
            S_DRAW: begin
                px_nxt = px + 4'd1;
                if (px == 4'd15) begin
                    if (col < 4'd9) begin
                        col_nxt   = col + 4'd1;
                        state_nxt = S_ADDR;
                    end else if (row < 5'd19) begin
                        col_nxt   = 4'd0;
                        row_nxt   = row + 5'd1;
                        state_nxt = S_ADDR;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // row*10 + col as shifts: row*8 + row*2 + col
    assign cell_idx = ({3'b000, row} << 3) + ({3'b000, row} << 1) + {4'b0000, col};

    always_comb begin
        ram_addr = 8'd0;
        X        = 8'd0;
        Y        = 7'd0;
        colour   = 6'd0;
        writeEn  = 1'b0;
        busy     = (state != S_IDLE);
        complete = (state == S_DONE);
        if (state == S_ADDR || state == S_LATCH || state == S_DRAW)
            ram_addr = cell_idx;
        if (state == S_DRAW) begin
            writeEn = 1'b1;
            X       = X0 + {2'b00, col, 2'b00} + {6'd0, px[1:0]};
            Y       = Y0 + {row, 2'b00} + {5'd0, px[3:2]};
            colour  = cell_colour;
        end
    end

endmodule
